// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, synchronous ROM addressing and the
// fetch/decode register with stall, redirect squash and interrupt entry.
module fetch_unit #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned INSTR_W = 18,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] INT_VECTOR = '1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               int_req,
  input  logic               int_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               valid_out,
  output logic               int_ack,
  output logic [ADDR_W-1:0]  int_ret_addr
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
    logic               valid;
  } fetch_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              rom_valid_q;
  logic              int_pend_q;
  logic              int_take;
  fetch_t            fr_q;
  fetch_t            fr_d;

  logic sel_redir;
  logic sel_int;
  logic sel_inc;
  logic sel_hold;

  assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign int_take = (int_pend_q | int_req) & int_en & ~stall
                  & ~redirect & rom_valid_q;

  // One-hot selects so the PC mux can be a unique decoder.
  assign sel_redir = rom_valid_q & redirect;
  assign sel_int   = int_take;
  assign sel_hold  = rom_valid_q & ~redirect & stall;
  assign sel_inc   = rom_valid_q & ~redirect & ~stall & ~int_take;

  always_comb begin
    next_pc = pc_q;
    unique case (1'b1)
      sel_redir: next_pc = redirect_addr;
      sel_int:   next_pc = INT_VECTOR;
      sel_hold:  next_pc = pc_q;
      sel_inc:   next_pc = pc_inc;
      default:   next_pc = pc_q;
    endcase
  end

  assign rom_addr = next_pc;

  always_comb begin
    fr_d = fr_q;
    if (redirect | int_take) begin
      fr_d.instr = NOP_INSTR;
      fr_d.valid = 1'b0;
    end else if (stall) begin
      fr_d = fr_q;
    end else if (!rom_valid_q) begin
      fr_d.valid = 1'b0;
    end else begin
      fr_d.instr = rom_instr;
      fr_d.addr  = pc_q;
      fr_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR;
      rom_valid_q <= 1'b0;
      int_pend_q  <= 1'b0;
    end else begin
      pc_q        <= next_pc;
      rom_valid_q <= 1'b1;
      int_pend_q  <= int_take ? 1'b0 : (int_pend_q | int_req);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_q.instr   <= NOP_INSTR;
      fr_q.addr    <= '0;
      fr_q.valid   <= 1'b0;
      int_ack      <= 1'b0;
      int_ret_addr <= '0;
    end else begin
      fr_q    <= fr_d;
      int_ack <= int_take;
      if (int_take) int_ret_addr <= pc_q;
    end
  end

  assign instr_out = fr_q.instr;
  assign addr_out  = fr_q.addr;
  assign valid_out = fr_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous ROM model
// returning {8'hA5, addr} for every address.
module tb_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          int_req = 1'b0;
  logic          int_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_instr = '0;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] addr_out;
  logic          valid_out;
  logic          int_ack;
  logic [AW-1:0] int_ret_addr;

  int n_assert = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .int_req(int_req),
    .int_en(int_en),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .instr_out(instr_out),
    .addr_out(addr_out),
    .valid_out(valid_out),
    .int_ack(int_ack),
    .int_ret_addr(int_ret_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_instr <= {8'hA5, rom_addr};

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [AW-1:0] a, input logic [IW-1:0] i);
    chk({tag, "_valid"}, 32'(valid_out), 32'(v));
    chk({tag, "_addr"}, 32'(addr_out), 32'(a));
    chk({tag, "_instr"}, 32'(instr_out), 32'(i));
  endtask

  initial begin
    #3;
    chk_out("rst", 1'b0, 10'h000, 18'h0);
    chk("rst_ack", 32'(int_ack), 32'd0);
    chk("rst_ret", 32'(int_ret_addr), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // startup latency and sequential fetch
    step();
    chk("s1_e1_valid", 32'(valid_out), 32'd0);
    step();
    chk_out("s1_e2", 1'b1, 10'h000, 18'h29400);
    step();
    chk_out("s1_e3", 1'b1, 10'h001, word(10'h001));
    step();
    chk_out("s1_e4", 1'b1, 10'h002, word(10'h002));
    step();
    step();
    step();
    chk_out("s2_pre", 1'b1, 10'h005, word(10'h005));

    // three-cycle stall
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("s2_hold", 1'b1, 10'h005, word(10'h005));
    end
    stall = 1'b0;
    step();
    chk_out("s2_rel0", 1'b1, 10'h006, word(10'h006));
    step();
    chk_out("s2_rel1", 1'b1, 10'h007, word(10'h007));

    // redirect overriding stall
    redirect = 1'b1;
    redirect_addr = 10'h120;
    stall = 1'b1;
    step();
    chk_out("s3_bub", 1'b0, 10'h007, 18'h0);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    chk_out("s3_tgt", 1'b1, 10'h120, word(10'h120));
    step();
    chk_out("s3_tgt1", 1'b1, 10'h121, word(10'h121));

    // interrupt accepted with pc_q = 0x042
    redirect = 1'b1;
    redirect_addr = 10'h042;
    step();
    chk("s4_pre_valid", 32'(valid_out), 32'd0);
    redirect = 1'b0;
    int_req = 1'b1;
    int_en = 1'b1;
    step();
    chk("s4_ack", 32'(int_ack), 32'd1);
    chk("s4_ret", 32'(int_ret_addr), 32'h042);
    chk("s4_bub_valid", 32'(valid_out), 32'd0);
    int_req = 1'b0;
    step();
    chk("s4_ack_low", 32'(int_ack), 32'd0);
    chk_out("s4_vec", 1'b1, 10'h3FF, word(10'h3FF));
    step();
    chk_out("s4_wrap", 1'b1, 10'h000, word(10'h000));

    // redirect and interrupt together: redirect wins, interrupt follows
    redirect = 1'b1;
    redirect_addr = 10'h200;
    int_req = 1'b1;
    step();
    chk("s4b_ack0", 32'(int_ack), 32'd0);
    chk("s4b_valid0", 32'(valid_out), 32'd0);
    redirect = 1'b0;
    int_req = 1'b0;
    step();
    chk("s4b_ack1", 32'(int_ack), 32'd1);
    chk("s4b_ret", 32'(int_ret_addr), 32'h200);
    chk("s4b_valid1", 32'(valid_out), 32'd0);
    step();
    chk("s4b_ack2", 32'(int_ack), 32'd0);
    chk_out("s4b_vec", 1'b1, 10'h3FF, word(10'h3FF));

    // pending interrupt waits out disable and stall
    int_en = 1'b0;
    int_req = 1'b1;
    step();
    chk("s4c_ack_dis", 32'(int_ack), 32'd0);
    chk_out("s4c_run", 1'b1, 10'h000, word(10'h000));
    int_req = 1'b0;
    int_en = 1'b1;
    stall = 1'b1;
    step();
    chk("s4c_ack_stall", 32'(int_ack), 32'd0);
    chk_out("s4c_hold", 1'b1, 10'h000, word(10'h000));
    stall = 1'b0;
    step();
    chk("s4c_ack", 32'(int_ack), 32'd1);
    chk("s4c_ret", 32'(int_ret_addr), 32'h001);
    chk("s4c_valid", 32'(valid_out), 32'd0);
    int_en = 1'b0;
    step();
    chk_out("s4c_vec", 1'b1, 10'h3FF, word(10'h3FF));

    // wrap across the top of the address space
    redirect = 1'b1;
    redirect_addr = 10'h3FE;
    step();
    chk("s5_bub", 32'(valid_out), 32'd0);
    redirect = 1'b0;
    step();
    chk_out("s5_a", 1'b1, 10'h3FE, word(10'h3FE));
    step();
    chk_out("s5_b", 1'b1, 10'h3FF, word(10'h3FF));
    step();
    chk_out("s5_c", 1'b1, 10'h000, word(10'h000));
    step();
    chk_out("s5_d", 1'b1, 10'h001, word(10'h001));

    // asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("s6_async", 1'b0, 10'h000, 18'h0);
    chk("s6_rom_addr", 32'(rom_addr), 32'd0);
    chk("s6_ret", 32'(int_ret_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("s6_e1_valid", 32'(valid_out), 32'd0);
    step();
    chk_out("s6_e2", 1'b1, 10'h000, 18'h29400);
    step();
    chk_out("s6_e3", 1'b1, 10'h001, word(10'h001));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
